// File: rtl/mem_responder.sv
// Word-addressed RAM answering the CPU's MAR/MDR strobes with a registered
// read-data/ready handshake and a configurable number of wait states.
module mem_responder #(
    parameter int    ADDR_WIDTH  = 9,
    parameter int    DATA_WIDTH  = 32,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [31:0]           mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_ready,
    output logic                  mem_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    op_wr_q;
    logic                    accept, enter_resp, active_req;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    req_wr;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^mar_addr[31:ADDR_WIDTH];

    // With zero wait states the access completes on the accepting edge, so the
    // live inputs must feed the array directly instead of the latched copies.
    assign req_addr  = (state == S_IDLE) ? mar_addr[ADDR_WIDTH-1:0] : addr_q;
    assign req_wdata = (state == S_IDLE) ? mdr_data : wdata_q;
    assign req_wr    = (state == S_IDLE) ? mem_write : op_wr_q;

    assign active_req = op_wr_q ? mem_write : mem_read;
    assign mem_busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!clear) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_n    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_n    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_n = active_req ? S_HOLD : S_IDLE;
            S_HOLD:  if (!mem_read && !mem_write) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt       <= '0;
            mem_ready <= 1'b0;
            Mdatain   <= '0;
        end else begin
            mem_ready <= enter_resp;
            if (accept) begin
                addr_q  <= mar_addr[ADDR_WIDTH-1:0];
                wdata_q <= mdr_data;
                op_wr_q <= mem_write;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !req_wr) Mdatain <= mem[req_addr];
        end
    end

    // A reset landing on the completion edge suppresses the write.
    always_ff @(posedge clk) begin
        if (clear && enter_resp && req_wr) mem[req_addr] <= req_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 2-wait-state and a zero-wait instance, checked every
// cycle against a transaction-level model plus literal expectations.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        clr  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] mdat [2];
    logic        rdy  [2];
    logic        busy [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) dut_w2 (
        .clk(clk), .clear(clr[0]), .mar_addr(addr[0]), .mdr_data(wd[0]),
        .mem_read(rd[0]), .mem_write(wr[0]), .Mdatain(mdat[0]),
        .mem_ready(rdy[0]), .mem_busy(busy[0]));

    mem_responder #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .clear(clr[1]), .mar_addr(addr[1]), .mdr_data(wd[1]),
        .mem_read(rd[1]), .mem_write(wr[1]), .Mdatain(mdat[1]),
        .mem_ready(rdy[1]), .mem_busy(busy[1]));

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // Transaction model: a request seen while free completes WS cycles later;
    // the pulse lasts one cycle and the block is free again once released.
    int          cyc = 0;
    int          phase [2];   // 0 free, 1 outstanding, 2 pulsing, 3 awaiting release
    int          due   [2];
    int          t_addr[2];
    logic [31:0] t_data[2];
    bit          t_wr  [2];
    logic [31:0] mm    [2][512];
    logic [31:0] e_data[2];
    logic        e_rdy [2];
    logic        e_busy[2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!clr[i]) begin
                e_data[i] = '0; e_rdy[i] = 1'b0; e_busy[i] = 1'b0; phase[i] = 0;
            end else begin
                e_rdy[i] = 1'b0;
                if (phase[i] == 2)
                    phase[i] = (t_wr[i] ? wr[i] : rd[i]) ? 3 : 0;
                else if (phase[i] == 3) begin
                    if (!rd[i] && !wr[i]) phase[i] = 0;
                end else if (phase[i] == 0 && (rd[i] || wr[i])) begin
                    t_addr[i] = int'(addr[i] % 512);
                    t_data[i] = wd[i];
                    t_wr[i]   = wr[i];
                    due[i]    = cyc + ((i == 0) ? 2 : 0);
                    phase[i]  = 1;
                end
                if (phase[i] == 1 && cyc == due[i]) begin
                    if (t_wr[i]) mm[i][t_addr[i]] = t_data[i];
                    else         e_data[i] = mm[i][t_addr[i]];
                    e_rdy[i] = 1'b1;
                    phase[i] = 2;
                end
                e_busy[i] = (phase[i] != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("model_ready", i, {31'd0, rdy[i]}, {31'd0, e_rdy[i]});
                check("model_busy", i, {31'd0, busy[i]}, {31'd0, e_busy[i]});
                check("model_mdatain", i, mdat[i], e_data[i]);
            end
        end
    end

    // Drive a request and return the number of falling edges until ready is seen.
    task automatic txn(input int i, input logic [31:0] a, input logic [31:0] d,
                       input bit r, input bit w, input bit hold, output int lat);
        @(negedge clk);
        addr[i] = a; wd[i] = d; rd[i] = r; wr[i] = w;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("ready_seen", i, (lat > 0) ? 32'd1 : 32'd0, 32'd1);
        if (!hold) begin
            rd[i] = 1'b0; wr[i] = 1'b0;
        end
    endtask

    initial begin
        int lat, pulses;
        logic [31:0] ir;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; addr[i] = '0; wd[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
            phase[i] = 0; e_data[i] = '0; e_rdy[i] = 1'b0; e_busy[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        clr[0] = 1'b1; clr[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_mdatain", 0, mdat[0], 32'h0);
        check("idle_ready", 0, {31'd0, rdy[0]}, 32'd0);
        check("idle_busy", 1, {31'd0, busy[1]}, 32'd0);

        // Write then read back with two wait states.
        txn(0, 32'h5A, 32'h389A8000, 1'b0, 1'b1, 1'b0, lat);
        check("w2_write_latency", 0, lat, 3);
        txn(0, 32'h5A, 32'h0, 1'b1, 1'b0, 1'b0, lat);
        check("w2_read_latency", 0, lat, 3);
        check("w2_read_data", 0, mdat[0], 32'h389A8000);

        // Zero wait: preload via a write, then a held read gives a single pulse.
        txn(1, 32'h10, 32'h00000012, 1'b0, 1'b1, 1'b0, lat);
        check("w0_write_latency", 1, lat, 1);
        txn(1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, lat);
        check("w0_read_latency", 1, lat, 1);
        check("w0_read_data", 1, mdat[1], 32'h00000012);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdy[1] === 1'b1) pulses++;
        end
        check("w0_hold_no_repulse", 1, pulses, 0);
        check("w0_hold_busy", 1, {31'd0, busy[1]}, 32'd1);
        rd[1] = 1'b0;
        @(negedge clk);

        // Both strobes high: write wins, upper address bits alias.
        txn(0, 32'h205, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, lat);
        check("prio_mdatain_kept", 0, mdat[0], 32'h389A8000);
        txn(0, 32'h005, 32'h0, 1'b1, 1'b0, 1'b0, lat);
        check("alias_read", 0, mdat[0], 32'hDEADBEEF);

        // Reset while a write is still waiting.
        txn(0, 32'h20, 32'h11111111, 1'b0, 1'b1, 1'b0, lat);
        @(negedge clk);
        addr[0] = 32'h20; wd[0] = 32'h22222222; wr[0] = 1'b1;
        @(negedge clk);
        check("midwrite_busy", 0, {31'd0, busy[0]}, 32'd1);
        clr[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", 0, {31'd0, busy[0]}, 32'd0);
        check("abort_mdatain", 0, mdat[0], 32'h0);
        clr[0] = 1'b1;
        txn(0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, lat);
        check("abort_not_committed", 0, mdat[0], 32'h11111111);

        // Instruction fetch from PC=0 with the stall counted by the requester.
        txn(0, 32'h0, 32'h389A8000, 1'b0, 1'b1, 1'b0, lat);
        txn(0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, lat);
        ir = mdat[0];
        check("fetch_ir", 0, ir, 32'h389A8000);
        check("fetch_stall_cycles", 0, lat - 1, 2);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
